ps2_rx: RTL and testbench



---
 rtl/ps2_rx.sv | 173 +++++++++++++++++
 tb/tb_ps2_rx.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx.sv
// ps2_rx: host-side PS/2 receiver; synchronizes and deglitches ps2_clk/ps2_data, decodes 11-bit frames into bytes.
// Latency: result pulses one clk after the filtered stop-bit falling edge (2 sync + FILTER_CYCLES cycles behind the pins).
// Backpressure: none; valid/parity_err/frame_err are single-cycle pulses the consumer must capture.

// One input line: 2-flop synchronizer followed by a hold-time glitch filter.
module ps2_rx_line #(
    parameter int FILTER_CYCLES = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level
);
    // Count reaching FILTER_CYCLES is detected one step early so a pulse of
    // exactly FILTER_CYCLES synchronized cycles flips the level.
    localparam logic [7:0] FILT_LAST = 8'(FILTER_CYCLES - 1);

    logic       sync_1;
    logic       sync_2;
    logic [7:0] cnt;

    // Two-flop synchronizer; idle level of the bus is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
        end else begin
            sync_1 <= din;
            sync_2 <= sync_1;
        end
    end

    // Filter: level follows the synchronized input only after it has differed for FILTER_CYCLES cycles in a row.
    always_ff @(posedge clk) begin
        if (reset) begin
            level <= 1'b1;
            cnt   <= 8'd0;
        end else if (sync_2 == level) begin
            cnt <= 8'd0;
        end else if (cnt == FILT_LAST) begin
            level <= sync_2;
            cnt   <= 8'd0;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end
endmodule

module ps2_rx #(
    parameter int FILTER_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] data,
    output logic       valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);
    // Timeout fires on the cycle where the counter would reach TIMEOUT_CYCLES,
    // putting frame_err exactly TIMEOUT_CYCLES+1 cycles after the last edge.
    localparam logic [19:0] TMO_LAST = 20'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t      state;
    logic        clk_filt;
    logic        data_filt;
    logic        clk_prev;
    logic        fe;
    logic [2:0]  bit_cnt;
    logic [7:0]  shreg;
    logic        par_ok;
    logic [19:0] tmo_cnt;

    ps2_rx_line #(.FILTER_CYCLES(FILTER_CYCLES)) u_clk_line (
        .clk   (clk),
        .reset (reset),
        .din   (ps2_clk),
        .level (clk_filt)
    );

    ps2_rx_line #(.FILTER_CYCLES(FILTER_CYCLES)) u_data_line (
        .clk   (clk),
        .reset (reset),
        .din   (ps2_data),
        .level (data_filt)
    );

    // Delayed copy of the filtered clock for falling-edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_prev <= 1'b1;
        end else begin
            clk_prev <= clk_filt;
        end
    end

    assign fe   = clk_prev & ~clk_filt;
    assign busy = (state != IDLE);

    // Frame decoder: steps on filtered clock falling edges; inter-edge timeout aborts a stalled frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            bit_cnt    <= 3'd0;
            shreg      <= 8'd0;
            par_ok     <= 1'b0;
            tmo_cnt    <= 20'd0;
            data       <= 8'd0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;

            if (state == IDLE) begin
                tmo_cnt <= 20'd0;
                // A high sample while idle is not a start bit; ignore silently.
                if (fe && !data_filt) begin
                    state   <= DATA;
                    bit_cnt <= 3'd0;
                end
            end else if (fe) begin
                // An edge in the timeout cycle wins: it is processed normally.
                tmo_cnt <= 20'd0;
                case (state)
                    DATA: begin
                        shreg   <= {data_filt, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= PARITY;
                        end
                    end
                    PARITY: begin
                        par_ok <= (^shreg) ^ data_filt;
                        state  <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if (!data_filt) begin
                            frame_err <= 1'b1;
                        end else if (par_ok) begin
                            data  <= shreg;
                            valid <= 1'b1;
                        end else begin
                            parity_err <= 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end else if (tmo_cnt == TMO_LAST) begin
                state     <= IDLE;
                frame_err <= 1'b1;
                tmo_cnt   <= 20'd0;
            end else begin
                tmo_cnt <= tmo_cnt + 20'd1;
            end
        end
    end
endmodule

// File: tb/tb_ps2_rx.sv
// tb_ps2_rx: directed frames through ps2_rx with a queue of expected result pulses.
// Latency: results checked on the clk falling edge as pulses appear.
// Backpressure: none; every pulse must match the head of the expected queue.
module tb_ps2_rx;
    localparam int F    = 4;
    localparam int T    = 300;
    localparam int HALF = 40;

    localparam int K_VALID = 0;
    localparam int K_PAR   = 1;
    localparam int K_FRAME = 2;

    typedef struct {
        int         kind;
        logic [7:0] dat;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    int         total = 0;
    int         bad = 0;
    exp_t       q[$];
    logic [7:0] exp_data = 8'h00;
    logic       prev_any = 1'b0;

    ps2_rx #(.FILTER_CYCLES(F), .TIMEOUT_CYCLES(T)) dut (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .data       (data),
        .valid      (valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input int kind, input logic [7:0] d);
        exp_t e;
        e.kind = kind;
        e.dat  = d;
        q.push_back(e);
    endtask

    // Scoreboard: every result pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (valid || parity_err || frame_err) begin
            int kind;
            exp_t e;
            kind = valid ? K_VALID : (parity_err ? K_PAR : K_FRAME);
            chk("one_hot", 32'(valid) + 32'(parity_err) + 32'(frame_err), 32'd1);
            chk("pulse_width", 32'(prev_any), 32'd0);
            chk("busy_at_pulse", 32'(busy), 32'd0);
            if (q.size() == 0) begin
                chk("unexpected_pulse", 32'(kind), 32'hFFFF);
            end else begin
                e = q.pop_front();
                chk("pulse_kind", 32'(kind), 32'(e.kind));
                chk("pulse_data", 32'(data), 32'(e.dat));
            end
        end
        prev_any <= valid | parity_err | frame_err;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic ps2_bit(input logic b);
        @(negedge clk) ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop_bit);
        logic p;
        p = ~(^b) ^ par_flip;
        if (!stop_bit)      push(K_FRAME, exp_data);
        else if (par_flip)  push(K_PAR, exp_data);
        else begin
            push(K_VALID, b);
            exp_data = b;
        end
        ps2_bit(1'b0);
        chk("busy_in_frame", 32'(busy), 32'd1);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(p);
        ps2_bit(stop_bit);
        @(negedge clk) ps2_data = 1'b1;
        chk("busy_after_frame", 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("rst_data", 32'(data), 32'h00);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_perr", 32'(parity_err), 32'd0);
        chk("rst_ferr", 32'(frame_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        repeat (20) @(negedge clk);

        // Good frame, bad parity, bad stop.
        send_frame(8'h1C, 1'b0, 1'b1);
        chk("data_1c", 32'(data), 32'h1C);
        repeat (2 * HALF) @(negedge clk);
        send_frame(8'h1C, 1'b1, 1'b1);
        chk("data_kept_par", 32'(data), 32'h1C);
        repeat (2 * HALF) @(negedge clk);
        send_frame(8'h1C, 1'b0, 1'b0);
        chk("data_kept_stop", 32'(data), 32'h1C);
        repeat (2 * HALF) @(negedge clk);

        // Glitch one cycle too short: ignored.
        ps2_data = 1'b0;
        repeat (20) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (F - 1) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (20) @(negedge clk);
        chk("glitch_short_busy", 32'(busy), 32'd0);

        // Exactly FILTER_CYCLES: taken as a start bit, then times out.
        push(K_FRAME, exp_data);
        ps2_clk = 1'b0;
        repeat (F) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (20) @(negedge clk);
        chk("glitch_exact_busy", 32'(busy), 32'd1);
        ps2_data = 1'b1;
        repeat (T + 50) @(negedge clk);
        chk("glitch_timeout_busy", 32'(busy), 32'd0);

        // Timeout after start + 3 data bits; measure from the last falling drive.
        push(K_FRAME, exp_data);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        @(negedge clk) ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        n = 0;
        while (n < T + 200) begin
            @(posedge clk);
            n++;
            #1;
            if (n == HALF) ps2_clk = 1'b1;
            if (frame_err) break;
        end
        chk("timeout_latency", 32'(n), 32'(F + T + 3));
        @(negedge clk);
        chk("timeout_busy", 32'(busy), 32'd0);
        repeat (2 * HALF) @(negedge clk);
        send_frame(8'hF0, 1'b0, 1'b1);
        chk("data_f0", 32'(data), 32'hF0);

        // Back-to-back with a one-bit gap.
        repeat (2 * HALF) @(negedge clk);
        send_frame(8'hF0, 1'b0, 1'b1);
        chk("b2b_first", 32'(data), 32'hF0);
        repeat (2 * HALF) @(negedge clk);
        send_frame(8'h1C, 1'b0, 1'b1);
        chk("b2b_second", 32'(data), 32'h1C);

        // Reset mid-frame discards it silently.
        repeat (2 * HALF) @(negedge clk);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b1);
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        exp_data = 8'h00;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_data", 32'(data), 32'h00);
        repeat (T + 50) @(negedge clk);
        send_frame(8'h5A, 1'b0, 1'b1);
        chk("after_rst_data", 32'(data), 32'h5A);

        repeat (100) @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
